// File: rtl/gp_reg_pkg.sv
// ============================================================================
// Module      : gp_reg_pkg
// Description : Op encoding shared by the general-purpose register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gp_reg_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_CLR  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_DEC  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // True for the ops that modify a register and the flags.
    function automatic logic op_is_exec(input logic [2:0] op);
        return (op != OP_NOP) && (op != OP_RSVD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gp_reg_alu.sv
// ============================================================================
// Module      : gp_reg_alu
// Description : Combinational next-value, carry and zero for one register op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gp_reg_alu
    import gp_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift_in,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_carry,
    output logic             o_zero
);

    localparam logic [WIDTH:0] c_ONE = {{WIDTH{1'b0}}, 1'b1};

    // INC/DEC run one bit wider so the carry/borrow falls out of the top bit.
    always_comb begin
        o_nxt   = i_cur;
        o_carry = 1'b0;
        case (i_op)
            OP_LOAD: o_nxt = i_data;
            OP_CLR:  o_nxt = '0;
            OP_INC:  {o_carry, o_nxt} = {1'b0, i_cur} + c_ONE;
            OP_DEC:  {o_carry, o_nxt} = {1'b0, i_cur} - c_ONE;
            OP_SHL:  {o_carry, o_nxt} = {i_cur, i_shift_in};
            OP_SHR:  {o_nxt, o_carry} = {i_shift_in, i_cur};
            default: ;
        endcase
    end

    assign o_zero = (o_nxt == '0);

endmodule

`default_nettype wire

// File: rtl/gp_reg_bank.sv
// ============================================================================
// Module      : gp_reg_bank
// Description : Addressed bank of general-purpose registers with flags and a
//               tristate read port onto the shared W-bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gp_reg_bank
    import gp_reg_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              shift_in,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              oe,
    output logic [WIDTH-1:0]  data_out,
    output logic              zero_flag,
    output logic              carry_flag
);

    // One extra bit so a non-power-of-two DEPTH can be range-checked.
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_zero;
    logic             r_carry;

    logic             w_wr_valid;
    logic             w_rd_valid;
    logic             w_exec;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_rd_val;
    logic             w_carry;
    logic             w_zero;

    assign w_wr_valid = ({1'b0, wr_addr} < c_DEPTH);
    assign w_rd_valid = ({1'b0, rd_addr} < c_DEPTH);
    assign w_exec     = en && w_wr_valid && op_is_exec(op);
    assign w_cur      = w_wr_valid ? r_regs[wr_addr] : '0;

    gp_reg_alu #(
        .WIDTH      (WIDTH)
    ) u_alu (
        .i_op       (op),
        .i_cur      (w_cur),
        .i_data     (data_in),
        .i_shift_in (shift_in),
        .o_nxt      (w_nxt),
        .o_carry    (w_carry),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_exec) begin
            r_regs[wr_addr] <= w_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_exec) begin
            r_zero  <= w_zero;
            r_carry <= w_carry;
        end
    end

    // Unmapped read addresses drive zeros rather than releasing the bus.
    assign w_rd_val   = w_rd_valid ? r_regs[rd_addr] : '0;
    assign data_out   = (en && oe) ? w_rd_val : {WIDTH{1'bz}};
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_gp_reg_bank.sv
// ============================================================================
// Module      : tb_gp_reg_bank
// Description : Self-checking bench for gp_reg_bank (8x4 and 16x3 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gp_reg_bank;
    import gp_reg_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, DEPTH=4
    logic       a_en, a_sin, a_oe;
    logic [2:0] a_op;
    logic [1:0] a_wa, a_ra;
    logic [7:0] a_din;
    wire  [7:0] a_bus;
    logic       a_z, a_c;

    // Instance B: WIDTH=16, DEPTH=3
    logic        b_en, b_sin, b_oe;
    logic [2:0]  b_op;
    logic [1:0]  b_wa, b_ra;
    logic [15:0] b_din;
    wire  [15:0] b_bus;
    logic        b_z, b_c;

    // An undriven bus floats high, so a released bus reads all-ones.
    pullup (a_bus);
    pullup (b_bus);

    gp_reg_bank #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .op(a_op), .wr_addr(a_wa),
        .data_in(a_din), .shift_in(a_sin), .rd_addr(a_ra), .oe(a_oe),
        .data_out(a_bus), .zero_flag(a_z), .carry_flag(a_c)
    );

    gp_reg_bank #(.WIDTH(16), .DEPTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .op(b_op), .wr_addr(b_wa),
        .data_in(b_din), .shift_in(b_sin), .rd_addr(b_ra), .oe(b_oe),
        .data_out(b_bus), .zero_flag(b_z), .carry_flag(b_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // ---------------- behavioural model ----------------
    longint ma [4];
    longint mb [3];
    bit     ma_z, ma_c, mb_z, mb_c;

    function automatic longint model_val(input int op, input longint old, input longint din,
                                         input bit sin, input int w);
        longint lim = longint'(1) << w;
        case (op)
            1: return din;
            2: return 0;
            3: return (old + 1) % lim;
            4: return (old + lim - 1) % lim;
            5: return (old * 2 + (sin ? 1 : 0)) % lim;
            6: return old / 2 + (sin ? lim / 2 : 0);
            default: return old;
        endcase
    endfunction

    function automatic bit model_cy(input int op, input longint old, input bit sin, input int w);
        longint lim = longint'(1) << w;
        case (op)
            3: return (old + 1) == lim;
            4: return old == 0;
            5: return (old * 2 + (sin ? 1 : 0)) >= lim;
            6: return (old % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (ma[i]) ma[i] <= 0;
            foreach (mb[i]) mb[i] <= 0;
            ma_z <= 0; ma_c <= 0; mb_z <= 0; mb_c <= 0;
        end else begin
            if (a_en && a_op >= 1 && a_op <= 6 && int'(a_wa) < 4) begin
                ma[a_wa] <= model_val(int'(a_op), ma[a_wa], longint'(a_din), a_sin, 8);
                ma_z     <= model_val(int'(a_op), ma[a_wa], longint'(a_din), a_sin, 8) == 0;
                ma_c     <= model_cy(int'(a_op), ma[a_wa], a_sin, 8);
            end
            if (b_en && b_op >= 1 && b_op <= 6 && int'(b_wa) < 3) begin
                mb[b_wa] <= model_val(int'(b_op), mb[b_wa], longint'(b_din), b_sin, 16);
                mb_z     <= model_val(int'(b_op), mb[b_wa], longint'(b_din), b_sin, 16) == 0;
                mb_c     <= model_cy(int'(b_op), mb[b_wa], b_sin, 16);
            end
        end
    end

    function automatic logic [31:0] exp_a_bus();
        if (!(a_en && a_oe)) return 32'h0000_00FF;
        return (int'(a_ra) < 4) ? 32'(ma[a_ra]) : 32'h0;
    endfunction

    function automatic logic [31:0] exp_b_bus();
        if (!(b_en && b_oe)) return 32'h0000_FFFF;
        return (int'(b_ra) < 3) ? 32'(mb[b_ra]) : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("model_a_bus",   32'(a_bus), exp_a_bus());
        check("model_a_zero",  32'(a_z),   32'(ma_z));
        check("model_a_carry", 32'(a_c),   32'(ma_c));
        check("model_b_bus",   32'(b_bus), exp_b_bus());
        check("model_b_zero",  32'(b_z),   32'(mb_z));
        check("model_b_carry", 32'(b_c),   32'(mb_c));
    endtask

    always @(negedge clk) begin
        if (chk_on) compare_all();
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc_a(input logic en, input logic [2:0] op, input logic [1:0] wa,
                         input logic [7:0] din, input logic sin, input logic [1:0] ra,
                         input logic oe);
        @(posedge clk); #2;
        a_en = en; a_op = op; a_wa = wa; a_din = din; a_sin = sin; a_ra = ra; a_oe = oe;
        @(negedge clk); #1;
    endtask

    task automatic cyc_b(input logic en, input logic [2:0] op, input logic [1:0] wa,
                         input logic [15:0] din, input logic sin, input logic [1:0] ra,
                         input logic oe);
        @(posedge clk); #2;
        b_en = en; b_op = op; b_wa = wa; b_din = din; b_sin = sin; b_ra = ra; b_oe = oe;
        @(negedge clk); #1;
    endtask

    task automatic expect_a(input string name, input logic [7:0] bus, input bit z, input bit c);
        check({name, "_bus"},   32'(a_bus), 32'(bus));
        check({name, "_zero"},  32'(a_z),   32'(z));
        check({name, "_carry"}, 32'(a_c),   32'(c));
    endtask

    task automatic expect_b(input string name, input logic [15:0] bus, input bit z, input bit c);
        check({name, "_bus"},   32'(b_bus), 32'(bus));
        check({name, "_zero"},  32'(b_z),   32'(z));
        check({name, "_carry"}, 32'(b_c),   32'(c));
    endtask

    initial begin
        rst_n = 1'b0;
        a_en = 0; a_op = OP_NOP; a_wa = 0; a_din = 0; a_sin = 0; a_ra = 0; a_oe = 0;
        b_en = 0; b_op = OP_NOP; b_wa = 0; b_din = 0; b_sin = 0; b_ra = 0; b_oe = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk_on = 1'b1;

        // Populate some state, then pull reset asynchronously mid-cycle
        cyc_a(1, OP_LOAD, 3, 8'h3C, 0, 3, 1); expect_a("pre_ld3c", 8'h00, 0, 0);
        cyc_a(1, OP_LOAD, 1, 8'hFF, 0, 3, 1); expect_a("ld3c",     8'h3C, 0, 0);
        cyc_a(1, OP_INC,  1, 8'h00, 0, 1, 1); expect_a("ldff",     8'hFF, 0, 0);
        cyc_a(1, OP_NOP,  0, 8'h00, 0, 1, 1); expect_a("incwrap0", 8'h00, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_zero",  32'(a_z), 32'h0);
        check("async_rst_carry", 32'(a_c), 32'h0);
        for (int i = 0; i < 4; i++) begin
            a_ra = 2'(i);
            #1 check($sformatf("rst_rd_r%0d", i), 32'(a_bus), 32'h0);
        end
        @(negedge clk); #2 rst_n = 1'b1;

        // Load and read-back, including a read in the write cycle
        cyc_a(1, OP_LOAD, 2, 8'hA5, 0, 2, 1); expect_a("rd_in_wr", 8'h00, 0, 0);
        cyc_a(1, OP_NOP,  0, 8'h00, 0, 2, 1); expect_a("ld_a5",    8'hA5, 0, 0);

        // INC wrap and DEC borrow
        cyc_a(1, OP_LOAD, 1, 8'hFF, 0, 1, 1);
        cyc_a(1, OP_INC,  1, 8'h00, 0, 1, 1); expect_a("ld_ff",      8'hFF, 0, 0);
        cyc_a(1, OP_DEC,  1, 8'h00, 0, 1, 1); expect_a("inc_wrap",   8'h00, 1, 1);
        cyc_a(1, OP_DEC,  1, 8'h00, 0, 1, 1); expect_a("dec_borrow", 8'hFF, 0, 1);
        cyc_a(1, OP_NOP,  0, 8'h00, 0, 1, 1); expect_a("dec_fe",     8'hFE, 0, 0);

        // Shifts
        cyc_a(1, OP_LOAD, 3, 8'h81, 0, 3, 1);
        cyc_a(1, OP_SHL,  3, 8'h00, 0, 3, 1); expect_a("ld_81", 8'h81, 0, 0);
        cyc_a(1, OP_SHR,  3, 8'h00, 1, 3, 1); expect_a("shl",   8'h02, 0, 1);
        cyc_a(1, OP_NOP,  0, 8'h00, 0, 3, 1); expect_a("shr",   8'h81, 0, 0);
        cyc_a(1, OP_CLR,  3, 8'h00, 0, 3, 1);
        cyc_a(1, OP_NOP,  0, 8'h00, 0, 3, 1); expect_a("clr",   8'h00, 1, 0);

        // Gating: en=0, oe=0, reserved op
        cyc_a(0, OP_LOAD, 0, 8'h55, 0, 0, 1); expect_a("en0_z",     8'hFF, 1, 0);
        cyc_a(1, OP_NOP,  0, 8'h00, 0, 0, 1); expect_a("en0_hold",  8'h00, 1, 0);
        cyc_a(1, OP_NOP,  0, 8'h00, 0, 0, 0); expect_a("oe0_z",     8'hFF, 1, 0);
        cyc_a(1, OP_RSVD, 2, 8'h00, 1, 2, 1); expect_a("pre_rsvd",  8'hA5, 1, 0);
        cyc_a(1, OP_NOP,  0, 8'h00, 0, 2, 1); expect_a("rsvd_hold", 8'hA5, 1, 0);

        // 16-bit, 3-entry instance
        cyc_b(1, OP_LOAD, 2, 16'hFFFF, 0, 2, 1); expect_b("b_pre",    16'h0000, 0, 0);
        cyc_b(1, OP_INC,  2, 16'h0000, 0, 2, 1); expect_b("b_ldffff", 16'hFFFF, 0, 0);
        cyc_b(1, OP_LOAD, 3, 16'h1234, 0, 2, 1); expect_b("b_incwrap",16'h0000, 1, 1);
        cyc_b(1, OP_NOP,  0, 16'h0000, 0, 3, 1); expect_b("b_oor_rd", 16'h0000, 1, 1);
        cyc_b(1, OP_LOAD, 0, 16'hBEEF, 0, 0, 1); expect_b("b_r0_old", 16'h0000, 1, 1);
        cyc_b(1, OP_NOP,  0, 16'h0000, 0, 0, 1); expect_b("b_r0",     16'hBEEF, 0, 0);
        cyc_b(1, OP_NOP,  0, 16'h0000, 0, 1, 1); expect_b("b_r1",     16'h0000, 0, 0);
        cyc_b(1, OP_NOP,  0, 16'h0000, 0, 0, 0); expect_b("b_oe0_z",  16'hFFFF, 0, 0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
